fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage feeding the decode/control stage. Owns the fetch PC,
//  issues word requests to instruction memory over a valid/ready handshake,
//  and presents {pc, instr} through the IF/ID register. Holds on decode stall,
//  squashes on branch/jump redirect, and injects `BUBBLE when it has no valid
//  instruction to present.
// PARAMETERS
//  RESET_PC   32'h0000_0000   first fetch address after reset
// PORTS
//  clk              in   1   clock; all state updates on the rising edge
//  rst_n            in   1   reset; asynchronous, active-low
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   memory accepts the request this cycle
//  imem_req_addr    out  32  word address of the request; [1:0] always 2'b00
//  imem_resp_valid  in   1   response valid; exactly one per accepted request, in order
//  imem_resp_data   in   32  instruction word
//  stall            in   1   decode cannot accept; IF/ID holds
//  redirect_valid   in   1   branch/jump resolved taken; squash the front end
//  redirect_pc      in   32  new fetch PC; bits [1:0] are ignored (forced to 0)
//  if_id_valid      out  1   IF/ID holds a real instruction
//  if_id_pc         out  32  PC of if_id_instr
//  if_id_instr      out  32  instruction to decode; `BUBBLE whenever if_id_valid=0
// BEHAVIOUR
//  Reset: state=REQ, fetch_pc=RESET_PC, skid empty, if_id_valid=0, if_id_pc=0,
//   if_id_instr=`BUBBLE. All outputs are registered or decoded from state only.
//   imem_req_valid=0 while rst_n=0; the first request is raised in the first
//   cycle after release. A reset mid-operation drops all in-flight state.
//  FSM (at most one request outstanding):
//   REQ : imem_req_valid = ~skid_valid; imem_req_addr = fetch_pc.
//         On handshake: fetch_pc <= fetch_pc+4 (mod 2^32, wraps to 0).
//         Next state is WAIT, or DROP when redirect_valid=1 in the same cycle.
//   WAIT: on imem_resp_valid without redirect: deliver {pc, data} -> REQ.
//         On redirect_valid: discard the response -> DROP, or -> REQ if
//         imem_resp_valid=1 in the same cycle.
//   DROP: imem_req_valid=0; on imem_resp_valid: discard -> REQ.
//  Redirect (highest priority, overrides stall):
//   fetch_pc <= {redirect_pc[31:2],2'b00}; if_id_valid<=0;
//   if_id_instr<=`BUBBLE; skid cleared. Latency: redirect in cycle N ->
//   request to redirect_pc in cycle N+1 (from REQ) or after the stale response.
//  Delivery: if IF/ID is empty, or stall=0, the response loads IF/ID directly.
//   Otherwise it loads the 1-entry skid buffer.
//  Stall: IF/ID holds its contents. On the first stall=0 cycle, a valid skid
//   entry moves into IF/ID. With stall=0 and nothing to deliver,
//   if_id_valid<=0 and if_id_instr<=`BUBBLE.
//  Skid full -> no new requests, so instructions are never lost or duplicated.
//  Program order of if_id_pc is strictly preserved: pc, pc+4, ... until a redirect.
// STRUCTURE
//  Constants: FETCH_ST_REQ/WAIT/DROP (2-bit) go in define/consts.v.
//   `BUBBLE is taken from define/instructions.v.
//  Sub-module fetch_skid_buffer: 1 entry, 64-bit {pc,instr}, with push/pop/
//   clear and a valid flag. Everything else is inline.
// TESTING
//  1 Reset release, ready=1, 1-cycle resp -> if_id_pc 0,4,8,... each instr
//    matches memory; if_id_instr=`BUBBLE while if_id_valid=0.
//  2 stall=1 for 5 cycles during streaming -> IF/ID frozen, one entry in skid,
//    imem_req_valid=0. Release -> next PCs appear in order, no gap or duplicate.
//  3 redirect_pc=32'h100 while in WAIT, resp 3 cycles later -> stale response
//    discarded, next request addr 32'h100, if_id shows 32'h100 next.
//  4 redirect together with stall=1 and skid full -> IF/ID=`BUBBLE (valid=0),
//    skid empty, fetch resumes at redirect_pc.
//  5 fetch_pc=32'hFFFF_FFFC -> next request addr 32'h0000_0000.
//    redirect_pc=32'h203 -> request addr 32'h200.
//  6 imem_req_ready held 0 for 4 cycles -> addr stable while valid=1, single
//    handshake, fetch_pc advances exactly once.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM state encoding, the bubble instruction and the IF/ID entry layout.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_ST_REQ  = 2'd0,
        FETCH_ST_WAIT = 2'd1,
        FETCH_ST_DROP = 2'd2
    } fetch_st_e;

    // addi x0, x0, 0
    localparam logic [31:0] BUBBLE = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_skid_buffer.sv
// One-entry holding slot for a fetched {pc, instr} that arrives while decode is stalled.
// Clear wins over push, push wins over pop.
module fetch_skid_buffer
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         valid,
    output fetch_entry_t dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    // Payload is only meaningful while valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding imem request at a time,
// and presents {pc, instr} through the IF/ID register with stall hold and redirect squash.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    fetch_st_e    state;
    fetch_st_e    state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  redirect_aligned;
    logic         handshake;
    logic         deliver;
    logic         load_if_id;
    logic         skid_valid;
    logic         skid_push;
    logic         skid_pop;
    fetch_entry_t skid_dout;
    fetch_entry_t resp_entry;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    // Request is held low during reset and while a skidded instruction is waiting.
    assign imem_req_valid = rst_n && (state == FETCH_ST_REQ) && !skid_valid;
    assign imem_req_addr  = fetch_pc;
    assign handshake      = imem_req_valid && imem_req_ready;

    assign deliver    = (state == FETCH_ST_WAIT) && imem_resp_valid && !redirect_valid;
    assign load_if_id = !if_id_valid || !stall;
    assign skid_push  = deliver && !load_if_id;
    assign skid_pop   = !redirect_valid && skid_valid && load_if_id;

    // fetch_pc already advanced on the handshake, so the response belongs to fetch_pc-4.
    assign resp_entry = {fetch_pc - 32'd4, imem_resp_data};

    fetch_skid_buffer u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (skid_push),
        .pop   (skid_pop),
        .clear (redirect_valid),
        .din   (resp_entry),
        .valid (skid_valid),
        .dout  (skid_dout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_ST_REQ: begin
                if (handshake) begin
                    state_nxt = redirect_valid ? FETCH_ST_DROP : FETCH_ST_WAIT;
                end
            end
            FETCH_ST_WAIT: begin
                if (redirect_valid) begin
                    state_nxt = imem_resp_valid ? FETCH_ST_REQ : FETCH_ST_DROP;
                end else if (imem_resp_valid) begin
                    state_nxt = FETCH_ST_REQ;
                end
            end
            FETCH_ST_DROP: begin
                if (imem_resp_valid) begin
                    state_nxt = FETCH_ST_REQ;
                end
            end
            default: state_nxt = FETCH_ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_ST_REQ;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
            end else if (handshake) begin
                fetch_pc <= pc_plus4(fetch_pc);
            end
        end
    end

    // IF/ID register: redirect squashes, stall holds, otherwise skid first then fresh response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_instr <= BUBBLE;
        end else if (redirect_valid) begin
            if_id_valid <= 1'b0;
            if_id_instr <= BUBBLE;
        end else if (load_if_id) begin
            if (skid_valid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= skid_dout.pc;
                if_id_instr <= skid_dout.instr;
            end else if (deliver) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= resp_entry.pc;
                if_id_instr <= resp_entry.instr;
            end else begin
                if_id_valid <= 1'b0;
                if_id_instr <= BUBBLE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a bench memory answers requests, expected {pc, instr}
// entries are queued on each accepted request and popped as decode consumes IF/ID.
module tb_fetch_unit;

    localparam logic [31:0] BUB = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [31:0] exp_next_pc = 32'h0;
    int          hs_cnt = 0;
    logic [31:0] hs_addr = 32'h0;
    int          resp_lat = 1;
    bit          mon_en = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(output logic [31:0] a);
        int start;
        start = hs_cnt;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (hs_cnt != start) break;
        end
        chk_eq("hs_seen", 32'(hs_cnt != start), 32'd1);
        a = hs_addr;
    endtask

    // Monitor: consume checks first, then new requests, then redirect flush.
    always @(negedge clk) begin
        if (mon_en) begin
            if (if_id_valid && !stall) begin
                chk_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_eq("if_id_pc", if_id_pc, e.pc);
                    chk_eq("if_id_instr", if_id_instr, e.instr);
                end
            end else if (!if_id_valid) begin
                chk_eq("bubble", if_id_instr, BUB);
            end
            if (imem_req_valid && imem_req_ready) begin
                chk_eq("req_addr", imem_req_addr, exp_next_pc);
                sb.push_back('{pc: exp_next_pc, instr: mem_word(exp_next_pc)});
                exp_next_pc = exp_next_pc + 32'd4;
                hs_addr = imem_req_addr;
                hs_cnt++;
            end
            if (redirect_valid) begin
                sb.delete();
                exp_next_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
    end

    // Memory responder: one response per accepted request after resp_lat cycles.
    initial begin
        int          seen;
        int          cnt;
        bit          busy;
        logic [31:0] addr;
        seen = 0;
        cnt  = 0;
        busy = 0;
        addr = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (hs_cnt != seen) begin
                chk_eq("one_outstanding", 32'(busy), 32'd0);
                seen = hs_cnt;
                cnt  = resp_lat;
                addr = hs_addr;
                busy = 1;
            end
            if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(addr);
                    busy = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) tick();

        chk_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk_eq("rst_if_id_valid", 32'(if_id_valid), 32'd0);
        chk_eq("rst_if_id_pc", if_id_pc, 32'h0);
        chk_eq("rst_if_id_instr", if_id_instr, BUB);

        rst_n  = 1'b1;
        mon_en = 1;
        #1;
        chk_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk_eq("first_req_addr", imem_req_addr, 32'h0);

        // Streaming with 1-cycle memory.
        repeat (14) tick();

        // Stall for 5 cycles: IF/ID frozen, skid fills, requests stop.
        stall = 1'b1;
        repeat (4) tick();
        chk_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk_eq("stall_if_id_valid", 32'(if_id_valid), 32'd1);
        chk_eq("stall_if_id_pc", if_id_pc, (sb.size() != 0) ? sb[0].pc : 32'hDEAD_BEEF);
        tick();
        stall = 1'b0;
        repeat (10) tick();

        // Redirect while waiting on a slow response.
        resp_lat = 3;
        wait_hs(a);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        wait_hs(a);
        chk_eq("redir_wait_addr", a, 32'h0000_0100);
        repeat (12) tick();

        // Redirect with stall held and skid full.
        resp_lat = 1;
        tick();
        stall = 1'b1;
        repeat (6) tick();
        chk_eq("skidfull_req_valid", 32'(imem_req_valid), 32'd0);
        chk_eq("skidfull_if_id_valid", 32'(if_id_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        chk_eq("squash_if_id_valid", 32'(if_id_valid), 32'd0);
        chk_eq("squash_if_id_instr", if_id_instr, BUB);
        chk_eq("squash_req_valid", 32'(imem_req_valid), 32'd1);
        chk_eq("squash_req_addr", imem_req_addr, 32'h0000_0040);
        stall = 1'b0;
        repeat (8) tick();

        // PC wrap at the top of the address space, then a misaligned redirect.
        wait_hs(a);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        wait_hs(a);
        chk_eq("wrap_addr0", a, 32'hFFFF_FFF8);
        wait_hs(a);
        chk_eq("wrap_addr1", a, 32'hFFFF_FFFC);
        wait_hs(a);
        chk_eq("wrap_addr2", a, 32'h0000_0000);
        wait_hs(a);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        wait_hs(a);
        chk_eq("align_addr", a, 32'h0000_0200);
        repeat (6) tick();

        // Memory back-pressure for 4 cycles.
        wait_hs(a);
        #1;
        imem_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_eq("bp_req_valid", 32'(imem_req_valid), 32'd1);
            chk_eq("bp_req_addr", imem_req_addr, a + 32'd4);
            tick();
        end
        imem_req_ready = 1'b1;
        begin
            logic [31:0] b;
            wait_hs(b);
            chk_eq("bp_single_hs", b, a + 32'd4);
            wait_hs(b);
            chk_eq("bp_next_hs", b, a + 32'd8);
        end

        // Drain: everything requested must have reached IF/ID exactly once.
        #1;
        imem_req_ready = 1'b0;
        repeat (10) tick();
        chk_eq("drain_sb_empty", 32'(sb.size()), 32'd0);

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
